// File: rtl/gf180mcu_ocd_io_cfg_loader.sv
// Serial configuration loader for the GF180MCU OCD pad ring.
// It keeps a per-pad shadow image, shifts it MSB-first into the pad config chain, then pulses LATCH.
module gf180mcu_ocd_io_cfg_loader #(
  parameter int unsigned NPADS   = 8,
  parameter int unsigned CFGW    = 6,
  parameter logic [CFGW-1:0] RST_CFG = CFGW'(6'b000010),
  localparam int unsigned AW     = $clog2(NPADS)
) (
  input  logic            CLK,
  input  logic            RN,
  inout  wire             DVDD,
  inout  wire             DVSS,
  inout  wire             VDD,
  inout  wire             VSS,
  input  logic            WR_VALID,
  output logic            WR_READY,
  input  logic [AW-1:0]   WR_ADDR,
  input  logic [CFGW-1:0] WR_DATA,
  input  logic            START,
  output logic            BUSY,
  output logic            SDO,
  output logic            SEN,
  output logic            LATCH,
  output logic            DONE,
  input  logic [AW-1:0]   RD_ADDR,
  output logic [CFGW-1:0] RD_DATA
);

  localparam int unsigned NBITS = NPADS * CFGW;
  localparam int unsigned CNTW  = $clog2(NBITS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_LATCH = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CFGW-1:0]   shadow_q [NPADS];
  logic [CFGW-1:0]   shadow_d [NPADS];
  logic [NBITS-1:0]  image_q, image_d;
  logic [NBITS-1:0]  flat_next;
  logic [NBITS-1:0]  shift_src;
  logic [CNTW-1:0]   cnt_q, cnt_d;

  logic wr_ready_q, wr_ready_d;
  logic busy_q, busy_d;
  logic sdo_q, sdo_d;
  logic sen_q, sen_d;
  logic latch_q, latch_d;
  logic done_q, done_d;

  logic wr_fire;

  // Power rails are feed-through only; fold them so they are visibly consumed.
  wire unused_pwr;
  assign unused_pwr = DVDD ^ DVSS ^ VDD ^ VSS;

  assign wr_fire = WR_VALID & wr_ready_q;

  // Shadow update; out-of-range write addresses match no pad and are dropped.
  always_comb begin
    flat_next = '0;
    for (int p = 0; p < int'(NPADS); p++) begin
      shadow_d[p] = shadow_q[p];
      if (wr_fire && (WR_ADDR == AW'(p))) begin
        shadow_d[p] = WR_DATA;
      end
      flat_next[p*CFGW +: CFGW] = shadow_d[p];
    end
  end

  // State register
  always_ff @(posedge CLK) begin
    if (!RN) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, bit counter and image snapshot
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    image_d = image_q;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d = S_SHIFT;
          cnt_d   = CNTW'(NBITS - 1);
          image_d = flat_next;
        end
      end
      S_SHIFT: begin
        if (cnt_q == '0) begin
          state_d = S_LATCH;
        end else begin
          cnt_d = cnt_q - CNTW'(1);
        end
      end
      S_LATCH: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the upcoming state so every output leaves a flop.
  always_comb begin
    shift_src  = (state_q == S_IDLE) ? flat_next : image_q;
    wr_ready_d = (state_d == S_IDLE);
    busy_d     = (state_d != S_IDLE);
    sen_d      = (state_d == S_SHIFT);
    sdo_d      = 1'b0;
    if (state_d == S_SHIFT) begin
      sdo_d = shift_src[cnt_d];
    end
    latch_d    = (state_d == S_LATCH);
    done_d     = (state_d == S_LATCH);
  end

  always_ff @(posedge CLK) begin
    if (!RN) begin
      cnt_q      <= '0;
      image_q    <= '0;
      wr_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      sdo_q      <= 1'b0;
      sen_q      <= 1'b0;
      latch_q    <= 1'b0;
      done_q     <= 1'b0;
      for (int p = 0; p < int'(NPADS); p++) begin
        shadow_q[p] <= RST_CFG;
      end
    end else begin
      cnt_q      <= cnt_d;
      image_q    <= image_d;
      wr_ready_q <= wr_ready_d;
      busy_q     <= busy_d;
      sdo_q      <= sdo_d;
      sen_q      <= sen_d;
      latch_q    <= latch_d;
      done_q     <= done_d;
      for (int p = 0; p < int'(NPADS); p++) begin
        shadow_q[p] <= shadow_d[p];
      end
    end
  end

  // Combinational readback; indices past the last pad read as zero.
  always_comb begin
    RD_DATA = '0;
    for (int p = 0; p < int'(NPADS); p++) begin
      if (RD_ADDR == AW'(p)) begin
        RD_DATA = shadow_q[p];
      end
    end
  end

  assign WR_READY = wr_ready_q;
  assign BUSY     = busy_q;
  assign SDO      = sdo_q;
  assign SEN      = sen_q;
  assign LATCH    = latch_q;
  assign DONE     = done_q;

endmodule

// File: tb/tb_gf180mcu_ocd_io_cfg_loader.sv
// Bench for the pad-ring config loader: cycle-timeline reference model plus directed and random stimulus.
module tb_gf180mcu_ocd_io_cfg_loader;
  localparam int NP = 8;
  localparam int CW = 6;
  localparam int N  = NP * CW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rn, wr_valid, start;
  logic [2:0] wr_addr, rd_addr;
  logic [5:0] wr_data;
  logic wr_ready, busy, sdo, sen, latch, done;
  logic [5:0] rd_data;
  wire dvdd, dvss, vdd, vss;
  assign dvdd = 1'b1;
  assign dvss = 1'b0;
  assign vdd  = 1'b1;
  assign vss  = 1'b0;

  gf180mcu_ocd_io_cfg_loader dut (
    .CLK(clk), .RN(rn), .DVDD(dvdd), .DVSS(dvss), .VDD(vdd), .VSS(vss),
    .WR_VALID(wr_valid), .WR_READY(wr_ready), .WR_ADDR(wr_addr), .WR_DATA(wr_data),
    .START(start), .BUSY(busy), .SDO(sdo), .SEN(sen), .LATCH(latch), .DONE(done),
    .RD_ADDR(rd_addr), .RD_DATA(rd_data)
  );

  int n_checks = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 = idle, 1..N = serial bit slots, N+1 = latch pulse.
  logic [CW-1:0] m_shadow [NP];
  logic [N-1:0]  m_image;
  int            m_phase = 0;
  bit            armed = 1'b0;

  always @(posedge clk) begin
    if (!rn) begin
      for (int p = 0; p < NP; p++) m_shadow[p] = 6'h02;
      m_phase = 0;
    end else if (m_phase == 0) begin
      if (wr_valid) m_shadow[wr_addr] = wr_data;
      if (start) begin
        for (int p = 0; p < NP; p++) m_image[p*CW +: CW] = m_shadow[p];
        m_phase = 1;
      end
    end else if (m_phase == N + 1) begin
      m_phase = 0;
    end else begin
      m_phase++;
    end
    armed = 1'b1;
  end

  int latch_cnt = 0;
  int done_cnt = 0;

  // Compare every output against the model mid-cycle.
  always @(negedge clk) begin
    if (armed) begin
      logic e_sen, e_sdo, e_lat;
      e_sen = (m_phase >= 1) && (m_phase <= N);
      e_sdo = e_sen ? m_image[N - m_phase] : 1'b0;
      e_lat = (m_phase == N + 1);
      chk("wr_ready", 32'(wr_ready), 32'(m_phase == 0));
      chk("busy", 32'(busy), 32'(m_phase != 0));
      chk("sen", 32'(sen), 32'(e_sen));
      chk("sdo", 32'(sdo), 32'(e_sdo));
      chk("latch", 32'(latch), 32'(e_lat));
      chk("done", 32'(done), 32'(e_lat));
      chk("rd_data", 32'(rd_data), 32'(m_shadow[rd_addr]));
      if (latch === 1'b1) latch_cnt++;
      if (done === 1'b1) done_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [2:0] a, input logic [5:0] d);
    int b;
    b = 0;
    wr_valid = 1'b1;
    wr_addr = a;
    wr_data = d;
    while (wr_ready !== 1'b1) begin
      step();
      b++;
      if (b > 200) begin
        n_checks++;
        n_err++;
        $display("FAIL wr_timeout: got ready=%b expected 1", wr_ready);
        break;
      end
    end
    step();
    wr_valid = 1'b0;
  endtask

  logic r_sen [1:60];
  logic r_sdo [1:60];
  logic r_lat [1:60];
  logic r_don [1:60];
  logic r_bsy [1:60];
  logic r_rdy [1:60];

  task automatic record(input int cycles);
    for (int c = 1; c <= cycles; c++) begin
      r_sen[c] = sen; r_sdo[c] = sdo; r_lat[c] = latch;
      r_don[c] = done; r_bsy[c] = busy; r_rdy[c] = wr_ready;
      step();
    end
  endtask

  initial begin
    int cnt, lc, dc;
    logic [5:0] s6;
    logic rest;
    rn = 1'b0; wr_valid = 1'b0; start = 1'b0;
    wr_addr = '0; wr_data = '0; rd_addr = '0;

    // Reset held two cycles
    step(); step();
    chk("rst_wr_ready", 32'(wr_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sen", 32'(sen), 32'd0);
    chk("rst_sdo", 32'(sdo), 32'd0);
    chk("rst_latch", 32'(latch), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    for (int a = 0; a < NP; a++) begin
      rd_addr = 3'(a);
      step();
      chk("rst_rd_data", 32'(rd_data), 32'h02);
    end
    rn = 1'b1;
    step();

    // Write and readback
    wr(3'd3, 6'h2D);
    wr(3'd7, 6'h3F);
    for (int a = 0; a < NP; a++) begin
      rd_addr = 3'(a);
      step();
      chk("readback", 32'(rd_data), (a == 3) ? 32'h2D : (a == 7) ? 32'h3F : 32'h02);
    end

    // Full load: only pad7 = 100001
    for (int p = 0; p < 7; p++) wr(3'(p), 6'h00);
    wr(3'd7, 6'b100001);
    start = 1'b1; step(); start = 1'b0;
    record(50);
    cnt = 0; rest = 1'b0;
    for (int c = 1; c <= 50; c++) if (r_sen[c]) cnt++;
    for (int c = 7; c <= 50; c++) rest |= r_sdo[c];
    s6 = {r_sdo[1], r_sdo[2], r_sdo[3], r_sdo[4], r_sdo[5], r_sdo[6]};
    chk("load_sen_cycles", 32'(cnt), 32'd48);
    chk("load_sen_c48", 32'(r_sen[48]), 32'd1);
    chk("load_first6", 32'(s6), 32'h21);
    chk("load_rest_zero", 32'(rest), 32'd0);
    chk("load_latch_c49", 32'(r_lat[49]), 32'd1);
    chk("load_done_c49", 32'(r_don[49]), 32'd1);
    chk("load_busy_c49", 32'(r_bsy[49]), 32'd1);
    chk("load_busy_c50", 32'(r_bsy[50]), 32'd0);

    // Collision: write pad0 with START, then a write held off while busy
    wr_valid = 1'b1; wr_addr = 3'd0; wr_data = 6'h01; start = 1'b1;
    step();
    start = 1'b0; wr_addr = 3'd1; wr_data = 6'h15;
    record(50);
    wr_valid = 1'b0;
    cnt = 0;
    for (int c = 1; c <= 49; c++) if (!r_rdy[c]) cnt++;
    chk("coll_last_bit", 32'(r_sdo[48]), 32'd1);
    chk("coll_ready_low", 32'(cnt), 32'd49);
    chk("coll_ready_c50", 32'(r_rdy[50]), 32'd1);
    rd_addr = 3'd1; #1;
    chk("coll_commit_pad1", 32'(rd_data), 32'h15);
    rd_addr = 3'd0; #1;
    chk("coll_pad0", 32'(rd_data), 32'h01);
    step();

    // Reset in the middle of a shift
    lc = latch_cnt;
    start = 1'b1; step(); start = 1'b0;
    for (int c = 1; c < 20; c++) step();
    rn = 1'b0; step(); rn = 1'b1;
    chk("midrst_sen", 32'(sen), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    for (int c = 0; c < 60; c++) step();
    chk("midrst_no_latch", 32'(latch_cnt - lc), 32'd0);
    rd_addr = 3'd7; #1;
    chk("midrst_shadow", 32'(rd_data), 32'h02);
    step();

    // START during a shift must be ignored
    dc = done_cnt;
    start = 1'b1; step(); start = 1'b0;
    cnt = 0;
    for (int c = 1; c <= 70; c++) begin
      start = (c == 10);
      if (sen) cnt++;
      step();
    end
    start = 1'b0;
    chk("ign_done_once", 32'(done_cnt - dc), 32'd1);
    chk("ign_sen_cycles", 32'(cnt), 32'd48);

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      rn       = ($urandom_range(0, 299) != 0);
      wr_valid = 1'($urandom_range(0, 1));
      wr_addr  = 3'($urandom);
      wr_data  = 6'($urandom);
      start    = ($urandom_range(0, 15) == 0);
      rd_addr  = 3'($urandom);
      step();
    end
    rn = 1'b1; wr_valid = 1'b0; start = 1'b0;
    for (int i = 0; i < 60; i++) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/gf180mcu_ocd_io_cfg_loader.md
# gf180mcu_ocd_io_cfg_loader

Synchronous serial configuration loader for the GF180MCU OCD I/O pad ring. It holds a shadow copy of per-pad control bits (output enable, input enable, pull-up, pull-down, slew, Schmitt) and, on command, shifts the whole image into the pad ring's daisy-chained config shift register, then pulses a latch. It sits in the core-side power domain, directly upstream of the pad cells and fillers that carry DVDD/DVSS/VDD/VSS around the ring.

## Interface
- NPADS, 8: number of pads in the chain (2..32).
- CFGW, 6: config bits per pad; bit order within a pad is {SCHMITT, SL, PD, PU, IE, OE} (bit 5..0).
- RST_CFG, 6'b000010: per-pad shadow value after reset (input enabled, all else off).

- CLK  input  1  core clock; all state on rising edge.
- RN  input  1  reset, synchronous, active-low.
- DVDD, DVSS, VDD, VSS  inout  1  power pins, pass-through only, no logic.
- WR_VALID  input  1  host write request.
- WR_READY  output  1  write accepted when WR_VALID & WR_READY.
- WR_ADDR  input  clog2(NPADS)  pad index.
- WR_DATA  input  CFGW  new config for that pad.
- START  input  1  begin full-chain load; sampled only in IDLE.
- BUSY  output  1  high from the cycle after START is accepted until load completes.
- SDO  output  1  serial data to chain.
- SEN  output  1  shift enable to chain; pad chain shifts on CLK rise when high.
- LATCH  output  1  one-cycle pulse transferring chain contents to pad controls.
- DONE  output  1  one-cycle pulse coincident with LATCH.
- RD_ADDR  input  clog2(NPADS)  readback index.
- RD_DATA  output  CFGW  combinational readback of shadow[RD_ADDR].

## Operation
- Shadow: NPADS x CFGW registers, each reset to RST_CFG.
- FSM states: IDLE, SHIFT, LATCH.
- IDLE: WR_READY=1, BUSY=0, SEN=0. Accepted write updates shadow[WR_ADDR] at that edge. WR_ADDR >= NPADS: handshake completes, shadow unchanged. START=1 -> SHIFT; bit counter loaded with NPADS*CFGW-1.
- SHIFT: WR_READY=0, BUSY=1, SEN=1. SDO = image bit selected by counter; image = concatenation shadow[NPADS-1] ... shadow[0], MSB first (pad NPADS-1 bit CFGW-1 first, pad 0 bit 0 last). Counter decrements each cycle; at 0 -> LATCH.
- LATCH: SEN=0, SDO=0, LATCH=1, DONE=1, BUSY=1, WR_READY=0; next state IDLE.
- Simultaneous WR_VALID and START in IDLE: write is committed at that edge; the shift uses the updated value.
- START while BUSY: ignored, not queued. WR_VALID while BUSY: held off by WR_READY=0; host must hold request.
- Shadow is snapshotted at shift start (image register), so readback during SHIFT returns the shadow, unaffected by shifting.
- Counter width clog2(NPADS*CFGW); no wrap: reaching 0 always exits SHIFT.

## Timing
- Reset values: WR_READY=1, BUSY=0, SDO=0, SEN=0, LATCH=0, DONE=0, state IDLE, counter 0, shadow=RST_CFG.
- All outputs except RD_DATA are registered.
- START accepted at edge 0 -> SEN=1 and first SDO bit valid in cycles 1..N (N=NPADS*CFGW), LATCH/DONE high in cycle N+1, BUSY low and WR_READY high in cycle N+2. Default N=48, total occupancy 49 cycles.
- Back-to-back: START may be accepted in cycle N+2, earliest.
- RN low on any edge, including mid-SHIFT: next cycle all outputs at reset values; LATCH is not pulsed, so pads retain previously latched config; shadow returns to RST_CFG.

## Test plan
- Reset: hold RN=0 two cycles -> WR_READY=1, BUSY/SEN/LATCH/DONE/SDO=0, RD_DATA=6'b000010 for every RD_ADDR.
- Write/readback: write pad3=6'h2D, pad7=6'h3F -> RD_ADDR=3 gives 6'h2D, RD_ADDR=7 gives 6'h3F, others 6'h02.
- Full load: shadow pad7=6'b100001, rest 0, START -> SEN high exactly 48 cycles, SDO=1,0,0,0,0,1 in cycles 1..6 then 0, LATCH=DONE=1 cycle 49, BUSY low cycle 50.
- Collision: WR_VALID(pad0=6'h01)+START same edge -> last serial bit (cycle 48) is 1; WR_VALID during BUSY sees WR_READY=0 until cycle 50, then commits.
- Mid-shift reset: RN=0 at cycle 20 of SHIFT -> SEN=0 next cycle, no LATCH pulse ever, shadow back to 6'h02.
- Ignored START: pulse START at cycle 10 of SHIFT -> single 48-bit load, exactly one DONE.
